adc_in: RTL and testbench

ADC_IN -- requirements
Module: ADC_IN

---
 rtl/spgd_fixed_pkg.sv | 16 +
 rtl/adc_accum.sv | 72 +++++++
 rtl/adc_in.sv | 112 +++++++++++
 tb/tb_adc_in.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/spgd_fixed_pkg.sv
// Fixed-point constants shared by the ADC input and DAC output paths.
// Voltage words are signed Q(INT).(FLOAT-INT); one ADC/DAC code is 5/4096 V.
package spgd_fixed_pkg;

  localparam int FLOAT_WIDTH_DEF = 64;
  localparam int ADC_WIDTH_DEF   = 14;
  localparam int INT_WIDTH_DEF   = 16;
  localparam int SCALE_MUL       = 5;
  localparam int SCALE_EXP       = 12;

  // Left shift that turns -(sum*5) into a fraction-aligned voltage after dividing by 2^avg_log2.
  function automatic int out_shift(input int float_w, input int int_w, input int avg_log2);
    return float_w - int_w - SCALE_EXP - avg_log2;
  endfunction

endpackage

// File: rtl/adc_accum.sv
// Block accumulator: sums 2^AVG_LOG2 accepted ADC samples and hands the
// completed sum to the conversion pipeline as a one-cycle pulse.
module adc_accum
  import spgd_fixed_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int AVG_LOG2  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic signed [ADC_WIDTH-1:0]            code,
  input  logic                                   code_valid,
  output logic signed [ADC_WIDTH+AVG_LOG2-1:0]   blk_sum,
  output logic                                   blk_valid
);

  localparam int SUM_W = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] sample_s;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    blk_valid_q, blk_valid_d;
  logic                    last_s;

  // Next-state for accumulator, sample counter and completed-block register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    blk_valid_d = 1'b0;
    sample_s    = SUM_W'(code);
    last_s      = (AVG_LOG2 == 0) ? 1'b1 : (&cnt_q);
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (code_valid) begin
      if (last_s) begin
        sum_d       = acc_q + sample_s;
        acc_d       = '0;
        cnt_d       = '0;
        blk_valid_d = 1'b1;
      end else begin
        acc_d = acc_q + sample_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      blk_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  assign blk_sum   = sum_q;
  assign blk_valid = blk_valid_q;

endmodule

// File: rtl/adc_in.sv
// ADC input path: block averaging, exact conversion to signed Q16.48 volts
// (V = -code*5/4096) and a valid/ready output register with sticky overrun.
module adc_in
  import spgd_fixed_pkg::*;
#(
  parameter int FLOAT_WIDTH = FLOAT_WIDTH_DEF,
  parameter int ADC_WIDTH   = ADC_WIDTH_DEF,
  parameter int INT_WIDTH   = INT_WIDTH_DEF,
  parameter int AVG_LOG2    = 4
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic signed [ADC_WIDTH-1:0]   ADC_CODE,
  input  logic                          ADC_VALID,
  input  logic                          CLEAR,
  output logic [FLOAT_WIDTH-1:0]        VOLT_OUT,
  output logic                          VOLT_VALID,
  input  logic                          VOLT_READY,
  output logic                          OVERRUN
);

  localparam int SUM_W  = ADC_WIDTH + AVG_LOG2;
  // |sum| <= 2^(SUM_W-1), so 5*|sum| < 2^(SUM_W+2): three extra bits hold the negated product.
  localparam int PROD_W = SUM_W + 3;
  localparam int SHIFT  = out_shift(FLOAT_WIDTH, INT_WIDTH, AVG_LOG2);
  localparam logic signed [PROD_W-1:0] MUL_S = PROD_W'(SCALE_MUL);

  logic signed [SUM_W-1:0]       blk_sum_s;
  logic                          blk_valid_s;
  logic signed [PROD_W-1:0]      sum_ext_s;
  logic signed [PROD_W-1:0]      prod_q, prod_d;
  logic                          pv_q, pv_d;
  logic signed [FLOAT_WIDTH-1:0] volt_ext_s;
  logic [FLOAT_WIDTH-1:0]        volt_new_s;
  logic [FLOAT_WIDTH-1:0]        volt_q, volt_d;
  logic                          vvalid_q, vvalid_d;
  logic                          ovr_q, ovr_d;

  adc_accum #(
    .ADC_WIDTH (ADC_WIDTH),
    .AVG_LOG2  (AVG_LOG2)
  ) u_accum (
    .clk        (CLK),
    .rst_n      (RSTN),
    .clear      (CLEAR),
    .code       (ADC_CODE),
    .code_valid (ADC_VALID),
    .blk_sum    (blk_sum_s),
    .blk_valid  (blk_valid_s)
  );

  // Scaling stage: negate and multiply the block sum by the code-to-volt numerator.
  always_comb begin
    prod_d    = prod_q;
    pv_d      = 1'b0;
    sum_ext_s = PROD_W'(blk_sum_s);
    if (CLEAR) begin
      pv_d = 1'b0;
    end else if (blk_valid_s) begin
      prod_d = -(sum_ext_s * MUL_S);
      pv_d   = 1'b1;
    end else begin
      prod_d = prod_q;
    end
  end

  // Output stage: align to the fixed-point format and run the valid/ready handshake.
  always_comb begin
    volt_ext_s = FLOAT_WIDTH'(prod_q);
    volt_new_s = volt_ext_s <<< SHIFT;
    volt_d     = volt_q;
    vvalid_d   = vvalid_q;
    ovr_d      = ovr_q;
    if (CLEAR) begin
      vvalid_d = 1'b0;
      ovr_d    = 1'b0;
    end else if (pv_q) begin
      if (!vvalid_q || VOLT_READY) begin
        volt_d   = volt_new_s;
        vvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vvalid_q && VOLT_READY) begin
      vvalid_d = 1'b0;
    end else begin
      vvalid_d = vvalid_q;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prod_q   <= '0;
      pv_q     <= 1'b0;
      volt_q   <= '0;
      vvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      pv_q     <= pv_d;
      volt_q   <= volt_d;
      vvalid_q <= vvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign VOLT_OUT   = volt_q;
  assign VOLT_VALID = vvalid_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_adc_in.sv
// Directed self-checking bench for adc_in with 4-sample averaging.
module tb_adc_in;

  localparam int FW = 64;
  localparam int AW = 14;
  localparam int AL = 2;

  localparam logic [FW-1:0] P10    = 64'h000A_0000_0000_0000;
  localparam logic [FW-1:0] M5     = 64'hFFFB_0000_0000_0000;
  localparam logic [FW-1:0] M_ONE4 = 64'hFFFF_FFB0_0000_0000;
  localparam logic [FW-1:0] M10    = 64'hFFF6_0050_0000_0000;

  localparam logic signed [AW-1:0] C_NEG_FS = 14'sh2000;
  localparam logic signed [AW-1:0] C_4096   = 14'sh1000;
  localparam logic signed [AW-1:0] C_ONE    = 14'sh0001;
  localparam logic signed [AW-1:0] C_POS_FS = 14'sh1FFF;

  logic                 CLK = 1'b0;
  logic                 RSTN;
  logic signed [AW-1:0] ADC_CODE;
  logic                 ADC_VALID;
  logic                 CLEAR;
  logic [FW-1:0]        VOLT_OUT;
  logic                 VOLT_VALID;
  logic                 VOLT_READY;
  logic                 OVERRUN;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [FW-1:0] got[$];

  adc_in #(
    .FLOAT_WIDTH (FW),
    .ADC_WIDTH   (AW),
    .INT_WIDTH   (16),
    .AVG_LOG2    (AL)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .ADC_CODE   (ADC_CODE),
    .ADC_VALID  (ADC_VALID),
    .CLEAR      (CLEAR),
    .VOLT_OUT   (VOLT_OUT),
    .VOLT_VALID (VOLT_VALID),
    .VOLT_READY (VOLT_READY),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Records a result consumed on the coming edge, then settles 2 ns past it.
  task automatic tick();
    if (VOLT_VALID === 1'b1 && VOLT_READY === 1'b1) got.push_back(VOLT_OUT);
    @(posedge CLK);
    #2;
  endtask

  task automatic feed(input logic signed [AW-1:0] code, input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      ADC_CODE  = code;
      ADC_VALID = 1'b1;
      tick();
      if (gappy) begin
        ADC_VALID = 1'b0;
        tick();
      end
    end
    ADC_VALID = 1'b0;
  endtask

  initial begin
    RSTN       = 1'b0;
    ADC_CODE   = '0;
    ADC_VALID  = 1'b0;
    CLEAR      = 1'b0;
    VOLT_READY = 1'b1;
    #12;
    check("rst_out",     VOLT_OUT,            64'd0);
    check("rst_valid",   64'(VOLT_VALID),     64'd0);
    check("rst_overrun", 64'(OVERRUN),        64'd0);
    RSTN = 1'b1;
    tick();

    // Full-scale negative block, latency of three edges from the final sample
    feed(C_NEG_FS, 4, 1'b0);
    check("lat_edge1", 64'(VOLT_VALID), 64'd0);
    tick();
    check("lat_edge2", 64'(VOLT_VALID), 64'd0);
    tick();
    check("lat_edge3_valid", 64'(VOLT_VALID), 64'd1);
    check("lat_edge3_out",   VOLT_OUT,        P10);
    tick();
    check("consumed_valid",  64'(VOLT_VALID), 64'd0);
    check("consumed_ovr",    64'(OVERRUN),    64'd0);

    // -5 V and one-LSB blocks
    got.delete();
    feed(C_4096, 4, 1'b0);
    repeat (4) tick();
    feed(C_ONE, 4, 1'b0);
    repeat (4) tick();
    check("pat_count", 64'(got.size()), 64'd2);
    check("pat_m5",    got[0],          M5);
    check("pat_one",   got[1],          M_ONE4);

    // Back-pressure: second result dropped, overrun sticky until CLEAR
    VOLT_READY = 1'b0;
    feed(C_4096, 4, 1'b0);
    feed(C_NEG_FS, 4, 1'b0);
    repeat (3) tick();
    check("ovr_valid", 64'(VOLT_VALID), 64'd1);
    check("ovr_held",  VOLT_OUT,        M5);
    check("ovr_flag",  64'(OVERRUN),    64'd1);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    check("clr_valid", 64'(VOLT_VALID), 64'd0);
    check("clr_ovr",   64'(OVERRUN),    64'd0);

    // Ready rises on the edge the second result arrives
    got.delete();
    feed(C_NEG_FS, 4, 1'b0);
    feed(C_4096, 4, 1'b0);
    tick();
    check("race_held_a",  VOLT_OUT,        P10);
    check("race_valid_a", 64'(VOLT_VALID), 64'd1);
    VOLT_READY = 1'b1;
    tick();
    check("race_out_b",   VOLT_OUT,        M5);
    check("race_valid_b", 64'(VOLT_VALID), 64'd1);
    check("race_ovr",     64'(OVERRUN),    64'd0);
    tick();
    check("race_drained", 64'(VOLT_VALID), 64'd0);
    check("race_count",   64'(got.size()), 64'd2);
    check("race_first",   got[0],          P10);
    check("race_second",  got[1],          M5);

    // Reset mid-block discards the partial sum
    got.delete();
    feed(C_4096, 2, 1'b0);
    RSTN = 1'b0;
    #3;
    check("mid_rst_out",   VOLT_OUT,        64'd0);
    check("mid_rst_valid", 64'(VOLT_VALID), 64'd0);
    RSTN = 1'b1;
    tick();
    feed(C_NEG_FS, 4, 1'b0);
    repeat (6) tick();
    check("mid_rst_count", 64'(got.size()), 64'd1);
    check("mid_rst_val",   got[0],          P10);

    // Gapped samples of +8191: partial blocks survive idle cycles
    got.delete();
    feed(C_POS_FS, 8, 1'b1);
    repeat (6) tick();
    check("gap_count",  64'(got.size()), 64'd2);
    check("gap_first",  got[0],          M10);
    check("gap_second", got[1],          M10);
    check("gap_ovr",    64'(OVERRUN),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
